// File: rtl/router_reg_gen_pkg.sv
// Shared definitions for the router register stage: header field helpers,
// error-code bits, parity mode selectors and the CRC update function.
// The helpers work on 64-bit carriers so any DATA_W up to 64 can use them;
// callers zero-extend operands and size-cast the result back down.
package router_pkg;

    localparam int HDR_MAX_W = 64;

    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_LEN    = 2'b10;

    localparam int PARITY_XOR = 0;
    localparam int PARITY_CRC = 1;

    // All-ones in the low w bits.
    function automatic logic [HDR_MAX_W-1:0] width_mask(input int w);
        if (w >= HDR_MAX_W)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    // Destination address field: header[addr_w-1:0].
    function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                      input int addr_w);
        return hdr & width_mask(addr_w);
    endfunction

    // Declared payload length field: header[data_w-1:addr_w].
    function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int data_w,
                                                     input int addr_w);
        return (hdr & width_mask(data_w)) >> addr_w;
    endfunction

    // One byte of MSB-first CRC: fold the byte in, then width shift steps with
    // a conditional polynomial XOR whenever the bit shifted out is set.
    function automatic logic [HDR_MAX_W-1:0] crc_step(input logic [HDR_MAX_W-1:0] acc,
                                                      input logic [HDR_MAX_W-1:0] b,
                                                      input logic [HDR_MAX_W-1:0] poly,
                                                      input int width);
        logic [HDR_MAX_W-1:0] c;
        logic [HDR_MAX_W-1:0] m;
        logic [HDR_MAX_W-1:0] top;
        m   = width_mask(width);
        top = 64'd1 << (width - 1);
        c   = (acc ^ b) & m;
        for (int i = 0; i < HDR_MAX_W; i++) begin
            if (i < width) begin
                if ((c & top) != '0)
                    c = ((c << 1) ^ poly) & m;
                else
                    c = (c << 1) & m;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/router_reg_gen_parity_acc.sv
// Packet parity accumulator: XOR or CRC over every header/payload byte.
// Clear has priority over enable so a new header always starts from zero.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                PARITY_MODE = PARITY_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY    = DATA_W'(8'h07)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_byte,
    output logic [DATA_W-1:0] o_acc
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_next;

    // Next accumulator value for the selected check mode.
    always_comb begin
        w_next = r_acc ^ i_byte;
        if (PARITY_MODE == PARITY_CRC)
            w_next = DATA_W'(crc_step(64'(r_acc), 64'(i_byte), 64'(CRC_POLY), DATA_W));
    end

    // Accumulator register: clear on header capture, update once per byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_next;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/router_reg_gen.sv
// Router datapath register stage: header hold, full-FIFO byte stash, output
// byte steering, parity accumulation, payload count and end-of-packet checks.
module router_reg_gen
    import router_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 2,
    parameter int                NUM_CH      = 3,
    parameter int                PARITY_MODE = PARITY_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY    = DATA_W'(8'h07),
    parameter int                LEN_CHECK   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     fifo_full,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic                     rst_int_reg,
    output logic [DATA_W-1:0]        dout,
    output logic                     parity_done,
    output logic                     low_pkt_valid,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [DATA_W-ADDR_W-1:0] byte_cnt
);

    localparam int LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] r_hold_hdr;
    logic [DATA_W-1:0] r_stash;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_pkt_parity;
    logic              r_parity_done;
    logic              r_parity_done_d;
    logic              r_low_pkt_valid;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [LEN_W-1:0]  r_byte_cnt;

    logic              w_addr_ok;
    logic              w_hdr_cap;
    logic              w_lfd;
    logic              w_ld;
    logic              w_laf;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_acc_op;
    logic [DATA_W-1:0] w_acc;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_pd_rise;
    logic              w_par_bad;
    logic              w_len_bad;
    logic [1:0]        w_err_code;

    // Strobes are pre-masked so each register sees a strict priority order:
    // header capture, then load-first-data, then load-data, then load-after-full.
    // full_state only ever means "hold", so it needs no strobe of its own.
    assign w_addr_ok = hdr_addr(64'(data_in), ADDR_W) < 64'(NUM_CH);
    assign w_hdr_cap = detect_add & pkt_valid & w_addr_ok;
    assign w_lfd     = ~w_hdr_cap & lfd_state;
    assign w_ld      = ~w_hdr_cap & ~lfd_state & ld_state;
    assign w_laf     = ~w_hdr_cap & ~lfd_state & ~ld_state & laf_state;

    // Header and payload bytes are accumulated exactly when they are accepted;
    // the stash replay in load-after-full is not accumulated again.
    assign w_acc_en  = w_lfd | (w_ld & pkt_valid);
    assign w_acc_op  = w_lfd ? r_hold_hdr : data_in;

    router_parity_acc #(
        .DATA_W      (DATA_W),
        .PARITY_MODE (PARITY_MODE),
        .CRC_POLY    (CRC_POLY)
    ) u_acc (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_hdr_cap),
        .i_en    (w_acc_en),
        .i_byte  (w_acc_op),
        .o_acc   (w_acc)
    );

    assign w_hdr_len  = LEN_W'(hdr_len(64'(r_hold_hdr), DATA_W, ADDR_W));
    assign w_pd_rise  = r_parity_done & ~r_parity_done_d;
    assign w_par_bad  = (w_acc != r_pkt_parity);
    assign w_len_bad  = (LEN_CHECK != 0) && (r_byte_cnt != w_hdr_len);
    assign w_err_code = (w_par_bad ? ERR_PARITY : 2'b00) | (w_len_bad ? ERR_LEN : 2'b00);

    // Header byte is held for replay in the load-first-data cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_hold_hdr <= '0;
        else if (w_hdr_cap)
            r_hold_hdr <= data_in;
    end

    // Output byte steering; dout freezes while the FIFO is full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_dout <= '0;
        else if (w_lfd)
            r_dout <= r_hold_hdr;
        else if (w_ld && !fifo_full)
            r_dout <= data_in;
        else if (w_laf)
            r_dout <= r_stash;
    end

    // Stash the byte (payload or parity) that arrives while the FIFO is full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stash <= '0;
        else if (w_ld && fifo_full)
            r_stash <= data_in;
    end

    // Payload byte counter, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_byte_cnt <= '0;
        else if (w_hdr_cap)
            r_byte_cnt <= '0;
        else if (w_ld && pkt_valid && (r_byte_cnt != '1))
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
    end

    // Parity byte capture and end-of-packet flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt_parity    <= '0;
            r_low_pkt_valid <= 1'b0;
            r_parity_done   <= 1'b0;
        end else if (w_hdr_cap) begin
            r_pkt_parity    <= '0;
            r_low_pkt_valid <= 1'b0;
            r_parity_done   <= 1'b0;
        end else begin
            if (w_ld && !pkt_valid)
                r_pkt_parity <= data_in;
            if (rst_int_reg)
                r_low_pkt_valid <= 1'b0;
            else if (w_ld && !pkt_valid)
                r_low_pkt_valid <= 1'b1;
            if (w_ld && !pkt_valid && !fifo_full)
                r_parity_done <= 1'b1;
            else if (w_laf && r_low_pkt_valid && !r_parity_done)
                r_parity_done <= 1'b1;
        end
    end

    // Error evaluation on the cycle after parity_done rises; held until next header.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity_done_d <= 1'b0;
            r_err           <= 1'b0;
            r_err_code      <= 2'b00;
        end else if (w_hdr_cap) begin
            r_parity_done_d <= 1'b0;
            r_err           <= 1'b0;
            r_err_code      <= 2'b00;
        end else begin
            r_parity_done_d <= r_parity_done;
            if (w_pd_rise) begin
                r_err_code <= w_err_code;
                r_err      <= |w_err_code;
            end
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign byte_cnt      = r_byte_cnt;

endmodule
